// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32 load/store unit: func3 codes, FSM states,
// byte-enable generation, load extraction/extension and access legality.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // func3[1:0] encodes the access size for both loads and stores
    function automatic logic [3:0] be_gen(input logic [2:0] func3, input logic [1:0] a);
        logic [3:0] be;
        case (func3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << a;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] func3, input logic [1:0] a,
                                             input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {a, 3'b000};
        case (func3)
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_W:    res = word;
            F3_BU:   res = {24'h000000, sh[7:0]};
            F3_HU:   res = {16'h0000, sh[15:0]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic access_ok(input logic store, input logic [2:0] func3,
                                       input logic [1:0] a);
        logic legal;
        logic aligned;
        case (func3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~store;
            default:          legal = 1'b0;
        endcase
        case (func3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~a[0];
            2'b10:   aligned = (a == 2'b00);
            default: aligned = 1'b0;
        endcase
        return legal & aligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request-side enables, store shifting and legality,
// plus extraction/extension of the returned read word using the latched access.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_store_i,
    input  logic [2:0]  req_func3_i,
    input  logic [1:0]  req_a_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  ld_func3_i,
    input  logic [1:0]  ld_a_i,
    input  logic [31:0] ld_word_i,
    output logic        ok_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] mask_s;

    // Store mask zeroes every byte that has no enable once shifted into its lane
    always_comb begin
        case (req_func3_i[1:0])
            2'b00:   mask_s = 32'h0000_00FF;
            2'b01:   mask_s = 32'h0000_FFFF;
            2'b10:   mask_s = 32'hFFFF_FFFF;
            default: mask_s = 32'h0000_0000;
        endcase
    end

    assign ok_o      = access_ok(req_store_i, req_func3_i, req_a_i);
    assign be_o      = be_gen(req_func3_i, req_a_i);
    assign wdata_o   = (req_wdata_i & mask_s) << {req_a_i, 3'b000};
    assign ld_data_o = load_ext(ld_func3_i, ld_a_i, ld_word_i);

endmodule

// File: rtl/lsu32.sv
// RV32 load/store unit: one req/gnt/rvalid bus transaction per accepted access,
// with timeout abort and registered response/bus outputs.
module lsu32
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  a_q, a_d;
    logic [2:0]  f3_q, f3_d;
    logic        st_q, st_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        ok_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ld_data_s;
    logic        accept_s;
    logic        timeout_s;

    lsu_align u_align (
        .req_store_i (req_store),
        .req_func3_i (req_func3),
        .req_a_i     (req_addr[1:0]),
        .req_wdata_i (req_wdata),
        .ld_func3_i  (f3_q),
        .ld_a_i      (a_q),
        .ld_word_i   (mem_rdata),
        .ok_o        (ok_s),
        .be_o        (be_s),
        .wdata_o     (wdata_s),
        .ld_data_o   (ld_data_s)
    );

    assign req_ready = (state_q == IDLE) && rst;
    assign accept_s  = req_valid && req_ready;
    // cnt_q counts completed cycles; this cycle is number cnt_q+1 of the budget
    assign timeout_s = ((cnt_q + 8'd1) >= TO_LIM);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            a_q          <= 2'b00;
            f3_q         <= 3'b000;
            st_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            f3_q         <= f3_d;
            st_q         <= st_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Next-state logic; a grant or rvalid on the limit cycle beats the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = ok_s ? ISSUE : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end else if (timeout_s) begin
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (mem_rvalid || timeout_s) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the counter, latched access and registered outputs
    always_comb begin
        cnt_d        = cnt_q;
        a_d          = a_q;
        f3_d         = f3_q;
        st_d         = st_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    cnt_d = 8'd0;
                    a_d   = req_addr[1:0];
                    f3_d  = req_func3;
                    st_d  = req_store;
                    if (ok_s) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_store;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = be_s;
                        mem_wdata_d = wdata_s;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                end else if (timeout_s) begin
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0000_0000;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = st_q ? 32'h0000_0000 : ld_data_s;
                end else if (timeout_s) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0000_0000;
                end else begin
                    resp_valid_d = 1'b0;
                end
            end
            RESP:    resp_valid_d = 1'b0;
            default: resp_valid_d = 1'b0;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu32.sv
// Scoreboard bench for lsu32: expected responses queued at accept, compared when
// resp_valid pulses; bus-side values and cycle timing checked inline.
module tb_lsu32;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lsu32 #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_err", 32'(resp_err), 32'(mon_e.err));
            end
        end
    end

    task automatic do_access(input string nm, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int gnt_wait, input logic [31:0] rd,
                             input logic [31:0] exp_rd, input logic exp_err,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        exp_t e;
        @(negedge clk);
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_store = st;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        chk({nm, "_busy"}, 32'(req_ready), 32'd0);
        if (exp_err) begin
            chk({nm, "_noreq"}, 32'(mem_req), 32'd0);
            chk({nm, "_errlat"}, 32'(resp_valid), 32'd1);
            @(negedge clk);
            chk({nm, "_noreq2"}, 32'(mem_req), 32'd0);
            chk({nm, "_pulse"}, 32'(resp_valid), 32'd0);
        end else begin
            for (int i = 0; i <= gnt_wait; i++) begin
                if (i > 0) @(negedge clk);
                chk({nm, "_req"}, 32'(mem_req), 32'd1);
                chk({nm, "_addr"}, mem_addr, {addr[31:2], 2'b00});
                chk({nm, "_be"}, 32'(mem_be), 32'(exp_be));
                chk({nm, "_we"}, 32'(mem_we), 32'(st));
                if (st) chk({nm, "_wdata"}, mem_wdata, exp_wd);
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            chk({nm, "_reqdrop"}, 32'(mem_req), 32'd0);
            chk({nm, "_early"}, 32'(resp_valid), 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            chk({nm, "_lat"}, 32'(resp_valid), 32'd1);
            chk({nm, "_rbusy"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            chk({nm, "_pulse"}, 32'(resp_valid), 32'd0);
            chk({nm, "_back"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        int cnt;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_func3  = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        rst = 1'b1;

        do_access("lw",   1'b0, F3_W,  32'h100, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0);
        do_access("lb",   1'b0, F3_B,  32'h103, 32'h0, 0, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 4'b1000, 32'h0);
        do_access("lbu",  1'b0, F3_BU, 32'h103, 32'h0, 0, 32'h80FF1234, 32'h00000080, 1'b0, 4'b1000, 32'h0);
        do_access("lhu",  1'b0, F3_HU, 32'h102, 32'h0, 1, 32'h80FF1234, 32'h000080FF, 1'b0, 4'b1100, 32'h0);
        do_access("lh",   1'b0, F3_H,  32'h102, 32'h0, 0, 32'h80FF1234, 32'hFFFF80FF, 1'b0, 4'b1100, 32'h0);
        do_access("lh0",  1'b0, F3_H,  32'h100, 32'h0, 0, 32'h80FF9234, 32'hFFFF9234, 1'b0, 4'b0011, 32'h0);
        do_access("lb1",  1'b0, F3_B,  32'h101, 32'h0, 0, 32'h80FF1234, 32'h00000012, 1'b0, 4'b0010, 32'h0);
        // grant on the last budgeted ISSUE cycle must still win over the timeout
        do_access("sh",   1'b1, F3_H,  32'h202, 32'h1234ABCD, 3, 32'hFFFFFFFF, 32'h0, 1'b0, 4'b1100, 32'hABCD0000);
        do_access("sb",   1'b1, F3_B,  32'h201, 32'h1234ABCD, 1, 32'hFFFFFFFF, 32'h0, 1'b0, 4'b0010, 32'h0000CD00);
        do_access("sw",   1'b1, F3_W,  32'h204, 32'hCAFEF00D, 0, 32'hFFFFFFFF, 32'h0, 1'b0, 4'b1111, 32'hCAFEF00D);
        do_access("lwmis", 1'b0, F3_W, 32'h102, 32'h0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        do_access("sill", 1'b1, F3_BU, 32'h200, 32'h0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        do_access("lhmis", 1'b0, F3_H, 32'h101, 32'h0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        do_access("lill", 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        do_access("shmis", 1'b1, F3_H, 32'h203, 32'h0, 0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);

        // Timeout: grant never comes
        @(negedge clk);
        chk("to_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_store = 1'b0;
        req_func3 = F3_W;
        req_addr  = 32'h300;
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        chk("to_reqcycles", 32'(cnt), 32'd4);
        chk("to_resp", 32'(resp_valid), 32'd1);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_gnt    = 1'b1;
        mem_rdata  = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        chk("late_noresp", 32'(resp_valid), 32'd0);
        chk("late_noreq", 32'(mem_req), 32'd0);
        do_access("lw2", 1'b0, F3_W, 32'h104, 32'h0, 0, 32'h11223344, 32'h11223344, 1'b0, 4'b1111, 32'h0);

        // Reset pulse while in WAIT
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_func3 = F3_W;
        req_addr  = 32'h400;
        req_wdata = 32'h55AA55AA;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rw_inwait", 32'(mem_req), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rw_ready", 32'(req_ready), 32'd0);
        chk("rw_rdata", resp_rdata, 32'd0);
        chk("rw_err", 32'(resp_err), 32'd0);
        chk("rw_req", 32'(mem_req), 32'd0);
        chk("rw_we", 32'(mem_we), 32'd0);
        chk("rw_addr", mem_addr, 32'd0);
        chk("rw_be", 32'(mem_be), 32'd0);
        chk("rw_wdata", mem_wdata, 32'd0);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rw_ready_back", 32'(req_ready), 32'd1);
        chk("rw_noresp", 32'(resp_valid), 32'd0);
        do_access("lw3", 1'b0, F3_HU, 32'h10A, 32'h0, 0, 32'hBEEF0000, 32'h0000BEEF, 1'b0, 4'b1100, 32'h0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
